// File: rtl/pc_seq_pkg.sv
// Shared constants and branch-condition evaluation for the pc_sequencer slice.
package pc_seq_pkg;

    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_CALL   = 3'b010;
    localparam logic [1:0] OP_BL      = 2'b11;

    localparam logic [2:0] COND_B  = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    function automatic logic cond_taken(input logic [2:0] cond, input logic n,
                                        input logic v, input logic z);
        logic t;
        t = 1'b0;
        case (cond)
            COND_B:  t = 1'b1;
            COND_EQ: t = z;
            COND_NE: t = ~z;
            COND_LT: t = n ^ v;
            COND_LE: t = (n ^ v) | z;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty only raises the sticky underflow flag.
module ras_stack #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    // wr_ptr_q is the next free slot, so the top of stack sits just below it.
    assign rd_ptr = wr_ptr_q - PW'(1);
    assign top    = mem_q[rd_ptr];
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (count_q == FULL_CNT) ovf_d = 1'b1;
            else                     count_d = count_q + (PW+1)'(1);
        end else if (pop) begin
            if (count_q == '0) begin
                unf_d = 1'b1;
            end else begin
                wr_ptr_d = rd_ptr;
                count_d  = count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with conditional branches and BL/BX handling.
// Define PC_SEQ_RAS_EN to add the hardware return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DISP_W    = 9,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_pc,
    input  logic                       reset_pc,
    input  logic [2:0]                 opcode,
    input  logic [1:0]                 op,
    input  logic [2:0]                 cond,
    input  logic [DISP_W-1:0]          disp,
    input  logic [15:0]                link_val,
    input  logic                       N,
    input  logic                       V,
    input  logic                       Z,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          old_pc,
    output logic                       taken,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_ovf,
    output logic                       ras_unf
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d, old_pc_q;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] disp_ext, seq_addr, br_addr, link_addr;
    logic              ras_push, ras_pop, ras_clear, ras_hit;
    logic [ADDR_W-1:0] ras_top;
    logic              unused_bits;

    generate
        if (DISP_W >= ADDR_W) begin : g_disp_trunc
            assign disp_ext = disp[ADDR_W-1:0];
        end else begin : g_disp_sext
            assign disp_ext = {{(ADDR_W-DISP_W){disp[DISP_W-1]}}, disp};
        end
    endgenerate

    // All targets wrap modulo 2^ADDR_W.
    assign seq_addr  = pc_q + ADDR_W'(1);
    assign br_addr   = seq_addr + disp_ext;
    assign link_addr = link_val[ADDR_W-1:0] + ADDR_W'(1);

    always_comb begin
        pc_d      = seq_addr;
        taken_d   = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        if (reset_pc) begin
            pc_d      = '0;
            ras_clear = 1'b1;
        end else if (opcode == OPC_BRANCH && op == 2'b00) begin
            if (cond_taken(cond, N, V, Z)) begin
                pc_d    = br_addr;
                taken_d = 1'b1;
            end
        end else if (opcode == OPC_CALL) begin
            taken_d = 1'b1;
            if (op == OP_BL) begin
                pc_d     = br_addr;
                ras_push = 1'b1;
            end else begin
                ras_pop = 1'b1;
                pc_d    = ras_hit ? ras_top : link_addr;
            end
        end
    end

`ifdef PC_SEQ_RAS_EN
    logic [CW-1:0] ras_cnt;

    ras_stack #(.WIDTH(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk     (clk),
        .rst_n   (reset),
        .push    (load_pc & ras_push),
        .pop     (load_pc & ras_pop),
        .clear   (load_pc & ras_clear),
        .data_in (seq_addr),
        .top     (ras_top),
        .count   (ras_cnt),
        .ovf     (ras_ovf),
        .unf     (ras_unf)
    );

    assign ras_hit     = (ras_cnt != '0);
    assign ras_count   = ras_cnt;
    assign unused_bits = ^{link_val, disp};
`else
    assign ras_hit     = 1'b0;
    assign ras_top     = '0;
    assign ras_count   = '0;
    assign ras_ovf     = 1'b0;
    assign ras_unf     = 1'b0;
    assign unused_bits = ^{link_val, disp, ras_push, ras_pop, ras_clear};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            old_pc_q <= '0;
            taken_q  <= 1'b0;
        end else if (load_pc) begin
            pc_q     <= pc_d;
            old_pc_q <= pc_q;
            taken_q  <= taken_d;
        end
    end

    assign pc     = pc_q;
    assign old_pc = old_pc_q;
    assign taken  = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int ADDR_W    = 9;
    localparam int DISP_W    = 9;
    localparam int RAS_DEPTH = 4;
    localparam int CW        = $clog2(RAS_DEPTH) + 1;
    localparam int MASK      = (1 << ADDR_W) - 1;

    logic              clk, reset, load_pc, reset_pc;
    logic [2:0]        opcode, cond;
    logic [1:0]        op;
    logic [DISP_W-1:0] disp;
    logic [15:0]       link_val;
    logic              N, V, Z;
    logic [ADDR_W-1:0] pc, old_pc;
    logic              taken;
    logic [CW-1:0]     ras_count;
    logic              ras_ovf, ras_unf;

    pc_sequencer #(.ADDR_W(ADDR_W), .DISP_W(DISP_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .reset(reset), .load_pc(load_pc), .reset_pc(reset_pc),
        .opcode(opcode), .op(op), .cond(cond), .disp(disp), .link_val(link_val),
        .N(N), .V(V), .Z(Z), .pc(pc), .old_pc(old_pc), .taken(taken),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state
    int m_pc, m_old, m_taken, m_ovf, m_unf;
    int ras_q[$];

    function automatic int m_count();
`ifdef PC_SEQ_RAS_EN
        return ras_q.size();
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", 32'(pc), m_pc);
            chk("old_pc", 32'(old_pc), m_old);
            chk("taken", 32'(taken), m_taken);
            chk("ras_count", 32'(ras_count), m_count());
            chk("ras_ovf", 32'(ras_ovf), m_ovf);
            chk("ras_unf", 32'(ras_unf), m_unf);
        end
    end

    function automatic void model_reset();
        m_pc = 0; m_old = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
        ras_q.delete();
    endfunction

    function automatic void model_advance(input bit rpc, input int opc, input int o, input int c,
                                          input int d, input int lv, input bit n_i, input bit v_i,
                                          input bit z_i);
        int seq, br, sd, nxt, tk;
        bit go;
        seq = (m_pc + 1) & MASK;
        sd  = d & 'h1FF;
        if (sd >= 256) sd = sd - 512;
        br  = (m_pc + 1 + sd) & MASK;
        nxt = seq;
        tk  = 0;
        if (rpc) begin
            nxt = 0;
            ras_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (opc == 1 && o == 0) begin
            case (c)
                0: go = 1'b1;
                1: go = z_i;
                2: go = !z_i;
                3: go = (n_i != v_i);
                4: go = (n_i != v_i) || z_i;
                default: go = 1'b0;
            endcase
            if (go) begin
                nxt = br;
                tk  = 1;
            end
        end else if (opc == 2) begin
            tk = 1;
            if (o == 3) begin
                nxt = br;
`ifdef PC_SEQ_RAS_EN
                if (ras_q.size() == RAS_DEPTH) begin
                    void'(ras_q.pop_front());
                    m_ovf = 1;
                end
                ras_q.push_back(seq);
`endif
            end else begin
`ifdef PC_SEQ_RAS_EN
                if (ras_q.size() > 0) begin
                    nxt = ras_q.pop_back();
                end else begin
                    nxt   = (lv + 1) & MASK;
                    m_unf = 1;
                end
`else
                nxt = (lv + 1) & MASK;
`endif
            end
        end
        m_old   = m_pc;
        m_pc    = nxt;
        m_taken = tk;
    endfunction

    task automatic step(input bit rpc, input int opc, input int o, input int c, input int d,
                        input int lv, input bit n_i, input bit v_i, input bit z_i);
        reset_pc = rpc;
        opcode   = 3'(opc);
        op       = 2'(o);
        cond     = 3'(c);
        disp     = DISP_W'(d);
        link_val = 16'(lv);
        N = n_i; V = v_i; Z = z_i;
        load_pc  = 1'b1;
        @(posedge clk);
        model_advance(rpc, opc, o, c, d, lv, n_i, v_i, z_i);
        #1;
        load_pc = 1'b0;
    endtask

    task automatic idle();
        load_pc  = 1'b0;
        reset_pc = 1'($urandom_range(0, 1));
        opcode   = 3'($urandom_range(0, 7));
        op       = 2'($urandom_range(0, 3));
        cond     = 3'($urandom_range(0, 7));
        disp     = DISP_W'($urandom);
        link_val = 16'($urandom);
        N = 1'($urandom); V = 1'($urandom); Z = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        load_pc = 1'b0;
        reset   = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", 32'(pc), 0);
        chk("async_rst_count", 32'(ras_count), 0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rpc();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; load_pc = 1'b0; reset_pc = 1'b0; opcode = '0; op = '0; cond = '0;
        disp = '0; link_val = '0; N = 0; V = 0; Z = 0;
        model_reset();
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        chk("reset_pc", 32'(pc), 0);
        chk("reset_taken", 32'(taken), 0);
        chk("reset_ovf", 32'(ras_ovf), 0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("adv_pc", 32'(pc), 3);
        chk("adv_old_pc", 32'(old_pc), 2);
        chk("adv_taken", 32'(taken), 0);

        rpc(); step(0, 1, 0, 0, 9, 0, 0, 0, 0);
        chk("to10", 32'(pc), 10);
        step(0, 1, 0, 1, 'h1FB, 0, 0, 0, 1);
        chk("beq_taken_pc", 32'(pc), 6);
        chk("beq_taken", 32'(taken), 1);
        rpc(); step(0, 1, 0, 0, 9, 0, 0, 0, 0);
        step(0, 1, 0, 1, 'h1FB, 0, 0, 0, 0);
        chk("beq_not_pc", 32'(pc), 11);
        chk("beq_not_taken", 32'(taken), 0);
        step(0, 1, 0, 4, 0, 0, 1, 0, 0);
        chk("ble_taken", 32'(taken), 1);
        chk("ble_pc", 32'(pc), 12);

        rpc(); step(0, 1, 0, 0, 'h1FE, 0, 0, 0, 0);
        chk("to511", 32'(pc), 511);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0);
        chk("wrap_br", 32'(pc), 1);
        rpc(); step(0, 1, 0, 0, 'h1FE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_seq", 32'(pc), 0);

        rpc(); step(0, 1, 0, 0, 19, 0, 0, 0, 0);
        chk("to20", 32'(pc), 20);
        step(0, 2, 3, 0, 10, 0, 0, 0, 0);
        chk("bl_pc", 32'(pc), 31);
        chk("bl_taken", 32'(taken), 1);
`ifdef PC_SEQ_RAS_EN
        chk("bl_count", 32'(ras_count), 1);
        step(0, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("bx_pc", 32'(pc), 21);
        chk("bx_count", 32'(ras_count), 0);

        rpc();
        repeat (5) step(0, 2, 3, 0, 0, 0, 0, 0, 0);
        chk("ovf_flag", 32'(ras_ovf), 1);
        chk("ovf_count", 32'(ras_count), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 2, 0, 0, 0, 0, 0, 0, 0);
            chk("ovf_ret", 32'(pc), 32'(5 - i));
        end
        step(0, 2, 1, 0, 0, 40, 0, 0, 0);
        chk("unf_pc", 32'(pc), 41);
        chk("unf_flag", 32'(ras_unf), 1);
        rpc();
        chk("clr_ovf", 32'(ras_ovf), 0);
        chk("clr_unf", 32'(ras_unf), 0);
`else
        step(0, 2, 0, 0, 0, 25, 0, 0, 0);
        chk("bx_nras_pc", 32'(pc), 26);
        chk("bx_nras_count", 32'(ras_count), 0);
`endif

        rpc();
        repeat (2) step(0, 2, 3, 0, 3, 0, 0, 0, 0);
        async_reset();

        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4)       rpc();
            else if (r < 40) step(0, 1, 0, $urandom_range(0, 7), $urandom, 0,
                                  1'($urandom), 1'($urandom), 1'($urandom));
            else if (r < 55) step(0, 2, 3, 0, $urandom, 0, 0, 0, 0);
            else if (r < 70) step(0, 2, $urandom_range(0, 2), 0, 0, $urandom, 0, 0, 0);
            else if (r < 85) step(0, $urandom_range(0, 7), $urandom_range(0, 3),
                                  $urandom_range(0, 7), $urandom, $urandom,
                                  1'($urandom), 1'($urandom), 1'($urandom));
            else if (r < 99) idle();
            else             async_reset();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
